modulo_multiplexador_display: RTL

//   Downstream consumer of the ripple frequency divider's clk_div output. Time-multiplexes N_DIGITS
//   BCD digits onto one common-anode 7-segment bus. Each digit is shown for one scan tick, with an
//   all-off blanking gap between digits to prevent ghosting. All logic runs on clk; clk_div is only

---
 rtl/modulo_multiplexador_display.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/modulo_multiplexador_display.sv
// Purpose : time-multiplexes N_DIGITS BCD digits onto one common-anode 7-segment bus.
// Latency : tick_in rise seen by the scan FSM two clk edges later; an/seg/dp are registered and change together.
// Backpress: none; ticks arriving while blanking are dropped, enable=0 darkens the display on the next edge.
//
// Ports:
//   clk      system clock, rising edge
//   clr      asynchronous active-low reset
//   tick_in  scan rate from the divider (clk_div), sampled as data through a 2-FF synchronizer
//   enable   1 = scan, 0 = display dark
//   digits   BCD digits, digit i at [4i+3:4i], digit 0 least significant
//   dp_in    decimal point per digit, 1 = lit
//   an       anode selects, active-low, one-hot-low while showing
//   seg      {g,f,e,d,c,b,a}, active-low
//   dp       decimal point, active-low
//   scan_idx index of the digit currently selected
//
// Build option: LEADING_ZERO_BLANK_EN blanks the segments of leading zero digits (digit 0 never blanked).

module modulo_multiplexador_display #(
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  tick_in,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [2:0]            scan_idx
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  // Counter load on BLANK entry; BLANK then lasts exactly BLANK_CYCLES cycles.
  localparam logic [7:0] BLANK_LOAD = (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);
  localparam logic [2:0] LAST_IDX   = 3'(N_DIGITS - 1);
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  logic sync1, sync2, prev;
  logic scan_tick;

  state_t                state, state_nx;
  logic [2:0]            idx_nx;
  logic [7:0]            cnt, cnt_nx;
  logic [4*N_DIGITS-1:0] snap, snap_nx;
  logic [N_DIGITS-1:0]   snap_dp, snap_dp_nx;

  logic [3:0]            cur_bcd;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [N_DIGITS-1:0]   an_nx;
  logic [6:0]            seg_nx;
  logic                  dp_nx;

  // Only a rising edge of the synchronized tick counts; held levels do nothing.
  assign scan_tick = sync2 & ~prev;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0010000;
      default: bcd_to_seg = 7'b0111111;
    endcase
  endfunction

  // Next-state logic. enable=0 wins over any tick.
  always_comb begin
    state_nx   = state;
    idx_nx     = scan_idx;
    cnt_nx     = cnt;
    snap_nx    = snap;
    snap_dp_nx = snap_dp;
    if (!enable) begin
      state_nx = IDLE;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_tick) begin
            snap_nx    = digits;
            snap_dp_nx = dp_in;
            idx_nx     = '0;
            state_nx   = (BLANK_CYCLES == 0) ? SHOW : BLANK;
            cnt_nx     = BLANK_LOAD;
          end
        end
        BLANK: begin
          // Ticks are ignored here on purpose.
          if (cnt == 8'd0) state_nx = SHOW;
          else             cnt_nx   = cnt - 8'd1;
        end
        SHOW: begin
          if (scan_tick) begin
            if (scan_idx == LAST_IDX) begin
              // Frame boundary: only here may new digit values enter.
              idx_nx     = '0;
              snap_nx    = digits;
              snap_dp_nx = dp_in;
            end else begin
              idx_nx = scan_idx + 3'd1;
            end
            state_nx = (BLANK_CYCLES == 0) ? SHOW : BLANK;
            cnt_nx   = BLANK_LOAD;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[i]: digit i and every higher digit of the next snapshot are zero.
  logic [N_DIGITS-1:0] lead_zero;
  always_comb begin
    lead_zero = '0;
    lead_zero[N_DIGITS-1] = (snap_nx[4*N_DIGITS-1 -: 4] == 4'd0);
    for (int i = N_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] & (snap_nx[4*i +: 4] == 4'd0);
    end
    lead_zero[0] = 1'b0;
  end
`endif

  // Outputs are decoded from the next-state view so an, seg and dp all
  // switch on the same edge as the state they belong to.
  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_nx     = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_nx == 3'(i)) begin
        cur_bcd = snap_nx[4*i +: 4];
        cur_dp  = snap_dp_nx[i];
`ifdef LEADING_ZERO_BLANK_EN
        cur_blank = lead_zero[i];
`endif
        if (state_nx == SHOW) an_nx[i] = 1'b0;
      end
    end
    if (state_nx == SHOW) begin
      seg_nx = cur_blank ? SEG_OFF : bcd_to_seg(cur_bcd);
      dp_nx  = ~cur_dp;
    end else begin
      seg_nx = SEG_OFF;
      dp_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      state    <= IDLE;
      scan_idx <= '0;
      cnt      <= '0;
      snap     <= '0;
      snap_dp  <= '0;
      an       <= '1;
      seg      <= SEG_OFF;
      dp       <= 1'b1;
    end else begin
      sync1    <= tick_in;
      sync2    <= sync1;
      prev     <= sync2;
      state    <= state_nx;
      scan_idx <= idx_nx;
      cnt      <= cnt_nx;
      snap     <= snap_nx;
      snap_dp  <= snap_dp_nx;
      an       <= an_nx;
      seg      <= seg_nx;
      dp       <= dp_nx;
    end
  end

endmodule
